// File: rtl/lv_bist_ctrl.sv
// lv_bist_ctrl: LV logic-BIST sequencer and scan-engine arbiter.
//   Starts a BIST run on a power-on edge or an on-demand request and holds
//   o_lbist_en for a fixed window. At the end of the window it samples the
//   lbist fail flag and retries a bounded number of times. It then latches a
//   final pass/fail status. It also shares the scan-register check engine
//   between the lbist and the functional periodic scanner.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_por_done, i_bist_start  run triggers (por rising edge / 1-cycle pulse)
//   o_lbist_en, i_lbist_fail  lbist enable and fail flag
//   o_bist_busy, o_bist_done  run in progress / 1-cycle completion pulse
//   o_bist_pass, o_bist_fail  latched result, held until the next start
//   o_attempt_cnt             attempts consumed in the last/current run
//   i_bist_scan_req, o_bist_scan_ack, o_bist_scan_err   lbist scan port
//   i_func_scan_req, o_func_scan_ack, o_func_scan_err   functional scan port
//   o_scan_req, i_scan_ack, i_scan_err                  shared scan engine
module lv_bist_ctrl #(
  parameter int unsigned CLK_M        = 48,
  parameter int unsigned BIST_WIN_CYC = 2000 * CLK_M + 8,
  parameter int unsigned BIST_GAP_CYC = 16,
  parameter int unsigned RETRY_MAX    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_por_done,
  input  logic       i_bist_start,
  output logic       o_lbist_en,
  input  logic       i_lbist_fail,
  output logic       o_bist_busy,
  output logic       o_bist_done,
  output logic       o_bist_pass,
  output logic       o_bist_fail,
  output logic [1:0] o_attempt_cnt,
  input  logic       i_bist_scan_req,
  output logic       o_bist_scan_ack,
  output logic       o_bist_scan_err,
  input  logic       i_func_scan_req,
  output logic       o_func_scan_ack,
  output logic       o_func_scan_err,
  output logic       o_scan_req,
  input  logic       i_scan_ack,
  input  logic       i_scan_err
);

  localparam int unsigned TMR_MAX = (BIST_WIN_CYC > BIST_GAP_CYC) ? BIST_WIN_CYC : BIST_GAP_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned MAX_ATT = RETRY_MAX + 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_CHK, S_GAP, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_BIST, OWN_FUNC} owner_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             win_fail_q, win_fail_d;
  logic [1:0]       att_d;
  logic             pass_d, fail_d, busy_d;
  logic             en_d, done_d;
  logic             por_q;
  logic             start_c;
  owner_t           owner_q, owner_d;
  logic             scan_req_d;

  // Start trigger; only meaningful in IDLE, so requests while busy are dropped.
  assign start_c = i_bist_start | (i_por_done & ~por_q);

  // Sequencer next-state and result/status next values.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    win_fail_d = win_fail_q;
    att_d      = o_attempt_cnt;
    pass_d     = o_bist_pass;
    fail_d     = o_bist_fail;
    busy_d     = o_bist_busy;
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_d    = S_RUN;
          tmr_d      = '0;
          win_fail_d = 1'b0;
          att_d      = 2'd1;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_RUN: begin
        // Timer stops at the last window cycle, so it never wraps.
        if (tmr_q == TMR_W'(BIST_WIN_CYC - 1)) begin
          win_fail_d = i_lbist_fail;
          state_d    = S_CHK;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_CHK: begin
        if (!win_fail_q) begin
          state_d = S_DONE;
          pass_d  = 1'b1;
        end else if (32'(o_attempt_cnt) < MAX_ATT) begin
          // The CHK cycle already has the enable low, so it is gap cycle 0.
          state_d = S_GAP;
          tmr_d   = TMR_W'(1);
        end else begin
          state_d = S_DONE;
          fail_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_q >= TMR_W'(BIST_GAP_CYC - 1)) begin
          state_d = S_RUN;
          tmr_d   = '0;
          att_d   = (o_attempt_cnt == 2'd3) ? o_attempt_cnt : o_attempt_cnt + 2'd1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    en_d   = (state_d == S_RUN);
    done_d = (state_q == S_DONE);
  end

  // Scan arbiter: grant only from NONE, release the cycle after the ack.
  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      OWN_NONE: begin
        if (o_lbist_en && i_bist_scan_req) begin
          owner_d = OWN_BIST;
        end else if (i_func_scan_req) begin
          owner_d = OWN_FUNC;
        end
      end
      OWN_BIST, OWN_FUNC: begin
        if (i_scan_ack) begin
          owner_d = OWN_NONE;
        end
      end
      default: owner_d = OWN_NONE;
    endcase
    scan_req_d = 1'b0;
    if (owner_d == OWN_BIST) begin
      scan_req_d = i_bist_scan_req;
    end else if (owner_d == OWN_FUNC) begin
      scan_req_d = i_func_scan_req;
    end
  end

  // Engine responses go to the current owner only.
  assign o_bist_scan_ack = (owner_q == OWN_BIST) & i_scan_ack;
  assign o_bist_scan_err = (owner_q == OWN_BIST) & i_scan_err;
  assign o_func_scan_ack = (owner_q == OWN_FUNC) & i_scan_ack;
  assign o_func_scan_err = (owner_q == OWN_FUNC) & i_scan_err;

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      tmr_q         <= '0;
      win_fail_q    <= 1'b0;
      por_q         <= 1'b0;
      owner_q       <= OWN_NONE;
      o_lbist_en    <= 1'b0;
      o_bist_busy   <= 1'b0;
      o_bist_done   <= 1'b0;
      o_bist_pass   <= 1'b0;
      o_bist_fail   <= 1'b0;
      o_attempt_cnt <= 2'd0;
      o_scan_req    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      win_fail_q    <= win_fail_d;
      por_q         <= i_por_done;
      owner_q       <= owner_d;
      o_lbist_en    <= en_d;
      o_bist_busy   <= busy_d;
      o_bist_done   <= done_d;
      o_bist_pass   <= pass_d;
      o_bist_fail   <= fail_d;
      o_attempt_cnt <= att_d;
      o_scan_req    <= scan_req_d;
    end
  end

endmodule

// File: tb/tb_lv_bist_ctrl.sv
// Self-checking bench for lv_bist_ctrl with a short window (40), gap 4 and one retry.
module tb_lv_bist_ctrl;

  localparam int unsigned WIN = 40;
  localparam int unsigned GAP = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_por_done, i_bist_start, i_lbist_fail;
  logic       i_bist_scan_req, i_func_scan_req, i_scan_ack, i_scan_err;
  logic       o_lbist_en, o_bist_busy, o_bist_done, o_bist_pass, o_bist_fail;
  logic [1:0] o_attempt_cnt;
  logic       o_bist_scan_ack, o_bist_scan_err, o_func_scan_ack, o_func_scan_err, o_scan_req;

  lv_bist_ctrl #(.CLK_M(48), .BIST_WIN_CYC(WIN), .BIST_GAP_CYC(GAP), .RETRY_MAX(1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_por_done(i_por_done), .i_bist_start(i_bist_start),
    .o_lbist_en(o_lbist_en), .i_lbist_fail(i_lbist_fail), .o_bist_busy(o_bist_busy),
    .o_bist_done(o_bist_done), .o_bist_pass(o_bist_pass), .o_bist_fail(o_bist_fail),
    .o_attempt_cnt(o_attempt_cnt), .i_bist_scan_req(i_bist_scan_req),
    .o_bist_scan_ack(o_bist_scan_ack), .o_bist_scan_err(o_bist_scan_err),
    .i_func_scan_req(i_func_scan_req), .o_func_scan_ack(o_func_scan_ack),
    .o_func_scan_err(o_func_scan_err), .o_scan_req(o_scan_req),
    .i_scan_ack(i_scan_ack), .i_scan_err(i_scan_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic pass;
    logic fail;
    int   att;
    int   wins;
  } exp_t;

  typedef struct {
    logic       start, breq, freq, ack, err;
    logic [7:0] exp;  // {en, scan_req, bist_ack, bist_err, func_ack, func_err, pass, fail}
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[12];
  int   errors = 0;
  int   checks = 0;
  int   pushed = 0;
  logic [2:0] fail_pat = 3'b000;

  // Window/gap observer.
  int   win_cnt = 0, run_len = 0, last_win = 0, low_len = 0, last_gap = 0, done_cnt = 0;
  logic en_prev = 1'b0;

  always @(negedge i_clk) begin
    if (o_bist_done) done_cnt <= done_cnt + 1;
    if (!i_rst_n) begin
      win_cnt <= 0; run_len <= 0; low_len <= 0; en_prev <= 1'b0;
    end else begin
      en_prev <= o_lbist_en;
      if (o_lbist_en) begin
        if (!en_prev) begin
          win_cnt  <= win_cnt + 1;
          last_gap <= low_len;
          run_len  <= 1;
        end else begin
          run_len <= run_len + 1;
        end
      end else begin
        if (en_prev) begin
          last_win <= run_len;
          low_len  <= 1;
        end else begin
          low_len <= low_len + 1;
        end
      end
      if (o_bist_done) win_cnt <= 0;
    end
  end

  // lbist fail flag follows the per-window pattern of the current test.
  assign i_lbist_fail = (win_cnt == 0) ? 1'b0 :
                        (win_cnt == 1) ? fail_pat[0] :
                        (win_cnt == 2) ? fail_pat[1] : fail_pat[2];

  logic [11:0] all_out;
  assign all_out = {o_lbist_en, o_bist_busy, o_bist_done, o_bist_pass, o_bist_fail, o_attempt_cnt,
                    o_bist_scan_ack, o_bist_scan_err, o_func_scan_ack, o_func_scan_err, o_scan_req};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_exp(input logic p, input logic f, input int a, input int w);
    exp_t e;
    e.pass = p; e.fail = f; e.att = a; e.wins = w;
    sb_q.push_back(e);
    pushed++;
  endtask

  task automatic wait_en(input logic lvl, input int max_cyc);
    bit seen = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (o_lbist_en == lvl) begin
        seen = 1;
        break;
      end
      step();
    end
    if (!seen) chk("wait_en_timeout", 0, 1);
  endtask

  // Waits for the done pulse, then pops and compares the expected run result.
  task automatic wait_done(input int max_cyc);
    exp_t e;
    bit seen = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (o_bist_done) begin
        seen = 1;
        break;
      end
      step();
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      return;
    end
    if (sb_q.size() == 0) begin
      chk("unexpected_done", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk("pass", int'(o_bist_pass), int'(e.pass));
      chk("fail", int'(o_bist_fail), int'(e.fail));
      chk("attempt_cnt", int'(o_attempt_cnt), e.att);
      chk("windows", win_cnt, e.wins);
      chk("win_len", last_win, int'(WIN));
      chk("done_lat", low_len, 2);
      chk("busy_at_done", int'(o_bist_busy), 0);
      if (e.wins > 1) chk("gap_len", last_gap, int'(GAP));
    end
    step();
  endtask

  initial begin
    int en_hi, busy_hi;
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'b00000001};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'b01000001};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'b11000000};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'b11001100};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'b10000000};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'b11000000};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'b11110000};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b10000000};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b11000000};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'b11001000};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b10000000};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b10000000};

    i_rst_n = 1'b0; i_por_done = 1'b0; i_bist_start = 1'b0;
    i_bist_scan_req = 1'b0; i_func_scan_req = 1'b0; i_scan_ack = 1'b0; i_scan_err = 1'b0;
    step(); step(); step();
    chk("reset_outputs", int'(all_out), 0);
    i_rst_n = 1'b1;
    step(); step();
    chk("idle_after_reset", int'(all_out), 0);

    // Power-on edge and explicit start in the same cycle: one run, clean pass.
    i_por_done = 1'b1; i_bist_start = 1'b1;
    push_exp(1'b1, 1'b0, 1, 1);
    step();
    i_bist_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("busy_in_run", int'(o_bist_busy), 1);
    chk("att_in_run", int'(o_attempt_cnt), 1);
    i_bist_start = 1'b1;  // ignored while busy
    step();
    i_bist_start = 1'b0;
    wait_done(200);
    for (int i = 0; i < 5; i++) step();
    chk("no_queued_start", int'({o_bist_busy, o_lbist_en}), 0);

    // First window fails, retry passes.
    fail_pat = 3'b001;
    i_bist_start = 1'b1;
    push_exp(1'b1, 1'b0, 2, 2);
    step();
    i_bist_start = 1'b0;
    wait_done(300);

    // Both windows fail; a start in the DONE cycle must be ignored.
    fail_pat = 3'b011;
    i_bist_start = 1'b1;
    push_exp(1'b0, 1'b1, 2, 2);
    step();
    i_bist_start = 1'b0;
    wait_en(1'b1, 10);
    wait_en(1'b0, 60);
    wait_en(1'b1, 20);
    wait_en(1'b0, 60);
    step();
    i_bist_start = 1'b1;
    step();
    i_bist_start = 1'b0;
    wait_done(10);
    en_hi = 0; busy_hi = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (o_lbist_en) en_hi++;
      if (o_bist_busy) busy_hi++;
    end
    chk("no_third_window", en_hi, 0);
    chk("start_in_done_ignored", busy_hi, 0);
    chk("fail_held", int'({o_bist_pass, o_bist_fail}), 1);
    fail_pat = 3'b000;

    // Arbiter vectors: FUNC in flight across en rise, BIST priority, error routing.
    for (int k = 0; k < 12; k++) begin
      i_bist_start = vecs[k].start; i_bist_scan_req = vecs[k].breq; i_func_scan_req = vecs[k].freq;
      i_scan_ack = vecs[k].ack; i_scan_err = vecs[k].err;
      if (vecs[k].start) push_exp(1'b1, 1'b0, 1, 1);
      #1;
      checks++;
      if ({o_lbist_en, o_scan_req, o_bist_scan_ack, o_bist_scan_err, o_func_scan_ack,
           o_func_scan_err, o_bist_pass, o_bist_fail} !== vecs[k].exp) begin
        errors++;
        $display("FAIL arb_vec[%0d]: got %b expected %b", k,
                 {o_lbist_en, o_scan_req, o_bist_scan_ack, o_bist_scan_err, o_func_scan_ack,
                  o_func_scan_err, o_bist_pass, o_bist_fail}, vecs[k].exp);
      end
      step();
    end
    i_bist_start = 1'b0; i_bist_scan_req = 1'b0; i_func_scan_req = 1'b0;
    i_scan_ack = 1'b0; i_scan_err = 1'b0;
    wait_done(200);

    // Reset 20 cycles into a run; the run is discarded.
    i_por_done = 1'b0;
    step();
    i_bist_start = 1'b1;
    step();
    i_bist_start = 1'b0;
    wait_en(1'b1, 10);
    i_func_scan_req = 1'b1;
    for (int i = 0; i < 10; i++) step();
    i_bist_start = 1'b1;
    step();
    i_bist_start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    i_scan_ack = 1'b1;
    #1;
    chk("func_ack_before_reset", int'(o_func_scan_ack), 1);
    i_rst_n = 1'b0;
    #1;
    chk("outputs_on_midrun_reset", int'(all_out), 0);
    i_scan_ack = 1'b0; i_func_scan_req = 1'b0;
    step(); step();
    i_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("idle_after_midrun_reset", int'(all_out), 0);

    // Fresh run; a BIST scan ack arriving after the window still reaches BIST.
    i_bist_start = 1'b1;
    push_exp(1'b1, 1'b0, 1, 1);
    step();
    i_bist_start = 1'b0;
    wait_en(1'b1, 10);
    chk("fresh_att", int'(o_attempt_cnt), 1);
    i_bist_scan_req = 1'b1;
    step(); step(); step();
    wait_en(1'b0, 60);
    chk("late_req_held", int'({o_scan_req, o_bist_scan_ack}), 2);
    i_scan_ack = 1'b1;
    #1;
    chk("late_ack_routed", int'({o_bist_scan_ack, o_func_scan_ack}), 2);
    step();
    i_scan_ack = 1'b0;
    chk("owner_cleared", int'(o_scan_req), 0);
    step();
    chk("no_grant_en_low", int'(o_scan_req), 0);
    i_bist_scan_req = 1'b0;
    wait_done(10);

    for (int i = 0; i < 5; i++) step();
    chk("done_count", done_cnt, pushed);
    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lv_bist_ctrl.md
Name: lv_bist_ctrl

Overview:
Sequencer and resource arbiter for the LV logic BIST.
- Starts a BIST run automatically after power-on or on an explicit request, and drives the lbist enable for a fixed window.
- Samples the lbist fail flag at the end of the window, retries a bounded number of times, and latches a final pass/fail status for the safety/fault logic.
- Arbitrates the shared scan-register check engine between the lbist and the functional periodic scanner.

Parameters:
- CLK_M, 48, clock frequency in MHz.
- BIST_WIN_CYC, 2000*CLK_M+8, cycles o_lbist_en is held per attempt; must be at least lbist timeout + 4.
- BIST_GAP_CYC, 16, idle cycles between a failed attempt and its retry.
- RETRY_MAX, 2, retries after the first failed attempt (total attempts = RETRY_MAX+1).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_por_done  in  1  level; rising edge triggers the power-on BIST
- i_bist_start  in  1  single-cycle on-demand start request
- o_lbist_en  out  1  enable to the lbist
- i_lbist_fail  in  1  fail flag from the lbist
- o_bist_busy  out  1  high while a run is in progress
- o_bist_done  out  1  single-cycle pulse at run completion
- o_bist_pass  out  1  latched result, valid when o_bist_done has occurred
- o_bist_fail  out  1  latched final fail
- o_attempt_cnt  out  2  attempts consumed in the last or current run
- i_bist_scan_req  in  1  scan request from the lbist
- o_bist_scan_ack  out  1  ack returned to the lbist
- o_bist_scan_err  out  1  error returned to the lbist
- i_func_scan_req  in  1  scan request from the functional scanner
- o_func_scan_ack  out  1  ack returned to the functional scanner
- o_func_scan_err  out  1  error returned to the functional scanner
- o_scan_req  out  1  request to the scan engine
- i_scan_ack  in  1  ack from the scan engine
- i_scan_err  in  1  error from the scan engine

Behaviour:
- Reset: all outputs are 0; FSM is in IDLE; timers, attempt count and arbiter owner are cleared.
- Reset mid-run forces IDLE immediately and discards any result.
- Start trigger = rising edge of i_por_done (registered edge detect) OR i_bist_start, sampled only in IDLE. Start requests while busy are ignored and not queued.
- FSM states:
  - IDLE -> RUN on start trigger. At the transition: clear o_bist_pass/o_bist_fail, set o_attempt_cnt=1, set o_bist_busy=1.
  - RUN: o_lbist_en=1; the window timer counts 0..BIST_WIN_CYC-1. In the last cycle, i_lbist_fail is sampled into a fail flag and the FSM goes to CHK.
  - CHK (1 cycle, o_lbist_en=0):
    - fail=0 -> DONE with pass=1.
    - fail=1 and attempt_cnt<RETRY_MAX+1 -> GAP.
    - otherwise -> DONE with fail=1.
  - GAP: o_lbist_en=0 for BIST_GAP_CYC cycles (this resets the lbist's internal counters), then attempt_cnt+1 and go to RUN.
  - DONE (1 cycle): o_bist_done=1, o_bist_busy=0 from the next cycle, then go to IDLE. o_bist_pass/o_bist_fail hold until the next start.
- o_lbist_en is registered and deasserts in the cycle after the sampling cycle. The window timer saturates and does not wrap.
- o_attempt_cnt saturates at 3.
- Scan arbiter:
  - Owner register with values NONE, BIST, FUNC.
  - Owner is granted only when owner==NONE and a request is present. BIST wins if o_lbist_en=1 and i_bist_scan_req=1; otherwise FUNC wins if i_func_scan_req=1.
  - o_scan_req = owner's request, registered, one cycle after grant.
  - i_scan_ack/i_scan_err are routed combinationally to the owner's ack/err only. The other requester sees 0.
  - Owner returns to NONE in the cycle after i_scan_ack. Simultaneous requests at an ack cycle are re-arbitrated on the following cycle.
  - No preemption: a FUNC transaction in flight completes before BIST is granted.
  - When o_lbist_en=0, BIST requests are never granted.
  - A late ack arriving after a run ends is still routed to BIST; the owner then clears.
- Simultaneous events:
  - i_bist_start and a por edge in the same cycle produce a single run.
  - A start in the DONE cycle is ignored.

Test Plan (BIST_WIN_CYC=40, BIST_GAP_CYC=4, RETRY_MAX=1):
1. Raise i_por_done with i_lbist_fail=0 -> o_lbist_en high for 40 cycles; o_bist_done pulses 2 cycles after o_lbist_en falls; pass=1, fail=0, attempt_cnt=1.
2. i_bist_start with i_lbist_fail=1 on the first window and 0 on the second -> en low for 4 cycles between windows; pass=1, attempt_cnt=2.
3. i_lbist_fail=1 in both windows -> exactly 2 windows, then done; fail=1, pass=0, attempt_cnt=2; no third window.
4. Both scan requests high with en=1 -> BIST is granted first; i_scan_err=1 reaches only o_bist_scan_err; FUNC is granted on the cycle after the ack.
5. FUNC in flight when en rises and the BIST request arrives -> BIST waits until i_scan_ack for FUNC, then is granted; no overlapping o_scan_req owners.
6. Deassert i_rst_n at cycle 20 of RUN -> all outputs 0 immediately; a later start begins a fresh run with attempt_cnt=1; i_bist_start while busy has no effect.
